// File: rtl/fifo_uart_tx_if.sv
// Read-side link between a synchronous FIFO (master) and the serial transmitter (slave).
// Handshake: fifo_rd_en pops one word on a clock edge when fifo_empty=0 and
// fifo_wr_en=0; that edge makes the popped word valid on fifo_dout.
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;

  modport master (
    output fifo_empty,
    output fifo_wr_en,
    output fifo_dout,
    input  fifo_rd_en
  );

  modport slave (
    input  fifo_empty,
    input  fifo_wr_en,
    input  fifo_dout,
    output fifo_rd_en
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 serial transmitter; pops one word, shifts it out LSB first.
// Optional even-parity bit between data and stop when PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic          clk,
  input  logic          reset,
  fifo_uart_tx_if.slave fifo,
  output logic          tx,
  output logic          busy,
  output logic          tx_done,
  output logic [2:0]    state_dbg
);
  localparam int               BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              rd_en_q;
  logic              baud_last;
  logic              bit_last;
  logic              pop_ok;
`ifdef PARITY_EN
  logic              parity_q;
`endif

  assign baud_last       = (baud_cnt == BAUD_LAST);
  assign bit_last        = (bit_cnt == BIT_LAST);
  // The FIFO gives a simultaneous write priority, so such a pop never happened.
  assign pop_ok          = !fifo.fifo_empty && !fifo.fifo_wr_en;
  assign fifo.fifo_rd_en = rd_en_q;
  assign state_dbg       = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_en_q <= 1'b0;
    end else begin
      state   <= state_next;
      rd_en_q <= (state_next == POP);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (!fifo.fifo_empty) state_next = POP;
      POP:    state_next = pop_ok ? LOAD : IDLE;
      LOAD:   state_next = START;
      START:  if (baud_last) state_next = DATA;
      DATA: begin
        if (baud_last && bit_last) begin
`ifdef PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: if (baud_last) state_next = STOP;
      STOP:   if (baud_last) state_next = fifo.fifo_empty ? IDLE : POP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx      = 1'b1;
    busy    = 1'b0;
    tx_done = 1'b0;
    case (state)
      LOAD:  busy = 1'b1;
      START: begin
        tx   = 1'b0;
        busy = 1'b1;
      end
      DATA: begin
        tx   = shift[0];
        busy = 1'b1;
      end
`ifdef PARITY_EN
      PARITY: begin
        tx   = parity_q;
        busy = 1'b1;
      end
`endif
      STOP: begin
        busy    = 1'b1;
        tx_done = baud_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          shift    <= fifo.fifo_dout;
`ifdef PARITY_EN
          parity_q <= ^fifo.fifo_dout;
`endif
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
        START, PARITY, STOP: baud_cnt <= baud_last ? '0 : baud_cnt + 16'd1;
        DATA: begin
          baud_cnt <= baud_last ? '0 : baud_cnt + 16'd1;
          if (baud_last) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO plus a line decoder that rebuilds each
// frame from tx samples and compares it with the bytes written, in order.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // FIFO model and DUT
  logic       fifo_empty = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fifo_dout = 8'h00;
  logic [7:0] fq[$];
  logic       tx, busy, tx_done;
  logic [2:0] state_dbg;

  fifo_uart_tx_if #(.DATA_W(8)) fbus ();
  assign fbus.fifo_empty = fifo_empty;
  assign fbus.fifo_wr_en = wr_en;
  assign fbus.fifo_dout  = fifo_dout;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo      (fbus),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .state_dbg (state_dbg)
  );

  always @(posedge clk) begin
    if (wr_en) fq.push_back(wr_data);
    else if (fbus.fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // line monitor
  logic [FRAME-1:0] tx_s, done_s, busy_s;
  int  k = 0;
  bit  in_frame = 0;
  int  frames_done = 0;
  int  start_q[$];
  int  stray_done = 0;
  int  rd_pulses = 0;
  int  rd_double = 0;
  bit  rd_prev = 0;

  task automatic check_frame();
    int hold_err;
    logic [7:0] got_b;
    logic [7:0] exp_b;
    hold_err = 0;
    for (int b = 0; b < NBITS; b++)
      for (int s = 1; s < CPB; s++)
        if (tx_s[b*CPB+s] !== tx_s[b*CPB]) hold_err++;
    for (int i = 0; i < 8; i++) got_b[i] = tx_s[(i+1)*CPB + CPB/2];
    check("bit_hold", hold_err, 0);
    check("stop_bit", tx_s[FRAME-1], 1'b1);
    check("tx_done_pos", done_s, 64'(1) << (FRAME-1));
    check("busy_in_frame", &busy_s, 1'b1);
    if (exp_q.size() == 0) begin
      check("unexpected_frame", got_b, 8'hxx);
    end else begin
      exp_b = exp_q.pop_front();
      check("frame_data", got_b, exp_b);
`ifdef PARITY_EN
      check("parity_bit", tx_s[9*CPB + CPB/2], ^exp_b);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0;
    end else begin
      if (in_frame || tx == 1'b0) begin
        if (!in_frame) begin
          in_frame = 1;
          k = 0;
          start_q.push_back(cyc);
        end
        tx_s[k] = tx;
        done_s[k] = tx_done;
        busy_s[k] = busy;
        k++;
        if (k == FRAME) begin
          check_frame();
          in_frame = 0;
          frames_done++;
        end
      end else if (tx_done) begin
        stray_done++;
      end
      if (fbus.fifo_rd_en && !rd_prev) rd_pulses++;
      if (fbus.fifo_rd_en && rd_prev) rd_double++;
    end
    rd_prev = fbus.fifo_rd_en;
  end

  // driver tasks
  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    wr_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_wait", frames_done >= target, 1'b1);
  endtask

  // counts negedges until the start bit appears, from the first sample after the call
  task automatic start_latency(output int lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, f0, s0, rd0, viol;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fbus.fifo_rd_en, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    reset = 1'b0;
    idle_cycles(3);

    // single byte
    f0 = frames_done; rd0 = rd_pulses;
    write_byte(8'hA5);
    wr_en = 1'b0;
    start_latency(lat);
    check("single_latency", lat, 3);
    wait_frames(f0 + 1, 200);
    idle_cycles(2);
    check("single_rd_pulses", rd_pulses - rd0, 1);
    check("single_fifo_empty", fifo_empty, 1'b1);

    // back-to-back, preloaded while the transmitter is held in reset
    @(posedge clk); #1;
    reset = 1'b1;
    write_byte(8'h01);
    write_byte(8'h80);
    write_byte(8'hFF);
    wr_en = 1'b0;
    f0 = frames_done; s0 = start_q.size(); rd0 = rd_pulses;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_frames(f0 + 3, 400);
    @(negedge clk);
    check("b2b_busy_after", busy, 1'b0);
    check("b2b_rd_pulses", rd_pulses - rd0, 3);
    if (start_q.size() >= s0 + 3) begin
      check("b2b_gap_1", start_q[s0+1] - start_q[s0], FRAME + 2);
      check("b2b_gap_2", start_q[s0+2] - start_q[s0+1], FRAME + 2);
    end else begin
      check("b2b_starts", start_q.size() - s0, 3);
    end
    idle_cycles(3);

    // write collision on the first pop
    f0 = frames_done; rd0 = rd_pulses;
    write_byte(8'h5A);
    write_byte(8'h11);
    write_byte(8'h22);
    wr_en = 1'b0;
    start_latency(lat);
    check("collide_latency", lat, 3);
    wait_frames(f0 + 3, 400);
    idle_cycles(2);
    check("collide_rd_pulses", rd_pulses - rd0, 4);

    // empty FIFO
    viol = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (fbus.fifo_rd_en || busy || tx_done || !tx) viol++;
    end
    check("empty_quiet", viol, 0);
    @(posedge clk); #1;

    // reset during data bit 3
    f0 = frames_done;
    write_byte(8'h3C);
    write_byte(8'h99);
    wr_en = 1'b0;
    start_latency(lat);
    repeat (17) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rd_en", fbus.fifo_rd_en, 1'b0);
    void'(exp_q.pop_front());
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_frames(f0 + 1, 200);
    check("midrst_frames", frames_done - f0, 1);
    idle_cycles(3);

    // parity corner bytes, then random traffic with random spacing
    f0 = frames_done;
    write_byte(8'h07);
    idle_cycles(60);
    write_byte(8'h03);
    idle_cycles(1);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 50));
      write_byte(8'($urandom_range(0, 255)));
    end
    wr_en = 1'b0;
    wait_frames(f0 + 22, 22 * (FRAME + 10) + 500);
    idle_cycles(5);

    // final report
    check("exp_q_drained", exp_q.size(), 0);
    check("stray_tx_done", stray_done, 0);
    check("rd_en_width", rd_double, 0);
    check("fifo_empty_end", fifo_empty, 1'b1);
    check("idle_busy_end", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
